req_dispatch: RTL

REQ_DISPATCH -- requirements
Module: req_dispatch

---
 rtl/calc_pkg.sv | 31 +++
 rtl/dispatch_credit.sv | 45 ++++
 rtl/req_dispatch.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// calc_pkg -- request packet type, execution-unit select codes and dispatcher
// state encoding shared by the calculator request path.
`default_nettype none

package calc_pkg;

   typedef struct packed {
      logic        req;
      logic [3:0]  req_type;
      logic [1:0]  req_id;
      logic [31:0] req_data1;
      logic [31:0] req_data2;
   } req_pkt_type;

   localparam logic [1:0] UNIT_ALU = 2'b00;
   localparam logic [1:0] UNIT_SHF = 2'b01;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND_ALU = 2'd1,
      SEND_SHF = 2'd2
   } disp_state_t;

   // The upper two req_type bits select the target execution unit.
   function automatic logic [1:0] unit_of(input req_pkt_type p);
      return p.req_type[3:2];
   endfunction

endpackage

`default_nettype wire

// File: rtl/dispatch_credit.sv
// dispatch_credit -- per-unit outstanding-request counter; grants credit while
// fewer than MAX_OUTST requests are in flight and flags stray completions.
`default_nettype none

module dispatch_credit #(
   parameter int MAX_OUTST = 2,
   parameter int CW        = $clog2(MAX_OUTST + 1) + 1
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          i_issue,
   input  logic          i_cpl,
   output logic [CW-1:0] o_outst,
   output logic          o_avail,
   output logic          o_err
);

   localparam logic [CW-1:0] c_MAX = CW'(MAX_OUTST);
   localparam logic [CW-1:0] c_ONE = CW'(1);

   logic [CW-1:0] r_outst;
   logic          r_err;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_outst <= '0;
         r_err   <= 1'b0;
      end else begin
         // A completion with nothing in flight is reported and otherwise ignored.
         r_err <= i_cpl && !i_issue && (r_outst == '0);
         case ({i_issue, i_cpl})
            2'b10:   r_outst <= r_outst + c_ONE;
            2'b01:   if (r_outst != '0) r_outst <= r_outst - c_ONE;
            default: r_outst <= r_outst;
         endcase
      end
   end

   assign o_outst = r_outst;
   assign o_avail = (r_outst < c_MAX);
   assign o_err   = r_err;

endmodule

`default_nettype wire

// File: rtl/req_dispatch.sv
// req_dispatch -- pops packets from the request FIFO head and hands them to
// the ALU or shifter over a valid/ready handshake, subject to per-unit credit.
`default_nettype none

module req_dispatch
   import calc_pkg::*;
#(
   parameter int MAX_OUTST = 2
) (
   input  logic        clk,
   input  logic        rst_b,
   input  req_pkt_type head_req,
   output logic        fifo_read,
   output logic        alu_valid,
   input  logic        alu_ready,
   output req_pkt_type alu_req,
   output logic        shf_valid,
   input  logic        shf_ready,
   output req_pkt_type shf_req,
   input  logic        alu_cpl,
   input  logic        shf_cpl,
   output logic        err_type,
   output logic        err_cpl,
   output logic [7:0]  issued_cnt
);

   localparam int CW = $clog2(MAX_OUTST + 1) + 1;

   disp_state_t r_state;
   disp_state_t w_next;

   logic        r_alu_valid;
   logic        r_shf_valid;
   req_pkt_type r_alu_req;
   req_pkt_type r_shf_req;
   logic [7:0]  r_issued_cnt;

   logic          w_fifo_read;
   logic          w_err_type;
   logic          w_load_alu;
   logic          w_load_shf;
   logic          w_alu_hs;
   logic          w_shf_hs;
   logic          w_alu_avail;
   logic          w_shf_avail;
   logic          w_alu_err;
   logic          w_shf_err;
   logic [CW-1:0] w_alu_outst;
   logic [CW-1:0] w_shf_outst;
   logic [1:0]    w_unit;

   assign w_unit   = unit_of(head_req);
   assign w_alu_hs = r_alu_valid && alu_ready;
   assign w_shf_hs = r_shf_valid && shf_ready;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_fifo_read = 1'b0;
      w_err_type  = 1'b0;
      w_load_alu  = 1'b0;
      w_load_shf  = 1'b0;
      case (r_state)
         IDLE: begin
            if (head_req.req) begin
               if (w_unit == UNIT_ALU) begin
                  if (w_alu_avail) begin
                     w_fifo_read = 1'b1;
                     w_load_alu  = 1'b1;
                     w_next      = SEND_ALU;
                  end
               end else if (w_unit == UNIT_SHF) begin
                  if (w_shf_avail) begin
                     w_fifo_read = 1'b1;
                     w_load_shf  = 1'b1;
                     w_next      = SEND_SHF;
                  end
               end else begin
                  w_fifo_read = 1'b1;
                  w_err_type  = 1'b1;
               end
            end
         end
         SEND_ALU: if (w_alu_hs) w_next = IDLE;
         SEND_SHF: if (w_shf_hs) w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   // Output registers clear on handshake so an idle interface always shows '0.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_alu_valid  <= 1'b0;
         r_shf_valid  <= 1'b0;
         r_alu_req    <= '0;
         r_shf_req    <= '0;
         r_issued_cnt <= 8'd0;
      end else begin
         if (w_load_alu) begin
            r_alu_valid <= 1'b1;
            r_alu_req   <= head_req;
         end else if (w_alu_hs) begin
            r_alu_valid <= 1'b0;
            r_alu_req   <= '0;
         end
         if (w_load_shf) begin
            r_shf_valid <= 1'b1;
            r_shf_req   <= head_req;
         end else if (w_shf_hs) begin
            r_shf_valid <= 1'b0;
            r_shf_req   <= '0;
         end
         if (w_alu_hs || w_shf_hs) r_issued_cnt <= r_issued_cnt + 8'd1;
      end
   end

   dispatch_credit #(
      .MAX_OUTST (MAX_OUTST),
      .CW        (CW)
   ) u_alu_credit (
      .clk     (clk),
      .rst_b   (rst_b),
      .i_issue (w_alu_hs),
      .i_cpl   (alu_cpl),
      .o_outst (w_alu_outst),
      .o_avail (w_alu_avail),
      .o_err   (w_alu_err)
   );

   dispatch_credit #(
      .MAX_OUTST (MAX_OUTST),
      .CW        (CW)
   ) u_shf_credit (
      .clk     (clk),
      .rst_b   (rst_b),
      .i_issue (w_shf_hs),
      .i_cpl   (shf_cpl),
      .o_outst (w_shf_outst),
      .o_avail (w_shf_avail),
      .o_err   (w_shf_err)
   );

   // The FSM sits in IDLE during reset, so the pop/error strobes are masked by rst_b.
   assign fifo_read  = w_fifo_read && rst_b;
   assign err_type   = w_err_type && rst_b;
   assign err_cpl    = w_alu_err || w_shf_err;
   assign alu_valid  = r_alu_valid;
   assign shf_valid  = r_shf_valid;
   assign alu_req    = r_alu_req;
   assign shf_req    = r_shf_req;
   assign issued_cnt = r_issued_cnt;

endmodule

`default_nettype wire
